// File: rtl/logic_unit_pkg.sv
// Shared op encoding and helpers for the pipelined logic unit.
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT     = 3'd0;
  localparam logic [OP_W-1:0] OP_AND     = 3'd1;
  localparam logic [OP_W-1:0] OP_OR      = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND    = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR     = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR     = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR    = 3'd6;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

  // Every code except the single reserved one is a valid operation.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return op != OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operation selected by op; illegal codes yield zero.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             illegal
);

  // Operation decode; b is unused for NOT.
  always_comb begin
    y       = '0;
    illegal = !is_legal_op(op);
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready logic lane: S1 holds operands, S2 holds the result
// and flags. Also keeps a saturating count of accepted illegal ops.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_cnt
);

  if (WIDTH < 1) begin : g_bad_width
    $error("logic_unit_pipe: WIDTH must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("logic_unit_pipe: CNT_W must be >= 1");
  end

  logic             s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]  s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q,      out_d;
  logic             zero_q,     zero_d;
  logic             err_q,      err_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic [WIDTH-1:0] core_y;
  logic             core_illegal;
  logic             s2_free, s1_move, in_xfer, out_xfer;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op      (s1_op_q),
    .a       (s1_a_q),
    .b       (s1_b_q),
    .y       (core_y),
    .illegal (core_illegal)
  );

  // Handshake, stage advance and counter next-state.
  always_comb begin
    s2_free  = !out_valid_q || out_ready;
    s1_move  = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid_q && out_ready;

    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    zero_d      = zero_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    // S1 drains into S2 and may refill in the same cycle.
    if (s1_move) s1_valid_d = 1'b0;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_a_d     = in1;
      s1_b_d     = in2;
    end

    if (out_xfer) out_valid_d = 1'b0;
    if (s1_move) begin
      out_valid_d = 1'b1;
      out_d       = core_y;
      zero_d      = (core_y == '0);
      err_d       = core_illegal;
    end

    // Clear wins over a simultaneous increment; count sticks at all-ones.
    if (clr_cnt)
      cnt_d = '0;
    else if (in_xfer && !is_legal_op(in_op) && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Pipeline and counter registers; reset flushes both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_zero  = zero_q;
  assign out_err   = err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=8, CNT_W=4): directed
// literal checks plus a queue-based reference model checked every cycle.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [7:0] in1, in2;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       out_zero;
  logic       out_err;
  logic [3:0] err_count;
  logic       clr_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] y;
    logic       z;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   mcnt = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_zero  (out_zero),
    .out_err   (out_err),
    .err_count (err_count),
    .clr_cnt   (clr_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the op table.
  function automatic exp_t ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t r;
    r.e = 1'b0;
    case (op)
      3'd0: r.y = ~a;
      3'd1: r.y = a & b;
      3'd2: r.y = a | b;
      3'd3: r.y = ~(a & b);
      3'd4: r.y = ~(a | b);
      3'd5: r.y = a ^ b;
      3'd6: r.y = ~(a ^ b);
      default: begin r.y = 8'h00; r.e = 1'b1; end
    endcase
    r.z = (r.y == 8'h00);
    return r;
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    in_op    = op;
    in1      = a;
    in2      = b;
  endtask

  task automatic do_reset();
    next();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    clr_cnt   = 1'b0;
    out_ready = 1'b1;
    repeat (2) next();
    rst_n = 1'b1;
  endtask

  // Scoreboard compare: in-order results, in_ready, hold under stall, counter.
  initial begin
    exp_t       e;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_out = 8'h00;
    logic       prev_z = 1'b0, prev_e = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        mcnt = 0;
        stall_prev = 1'b0;
      end else begin
        chk("sb_err_count", err_count, mcnt);
        chk("sb_in_ready", in_ready, !(sb.size() >= 2 && !out_ready));
        if (stall_prev) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_out", out, prev_out);
          chk("hold_zero", out_zero, prev_z);
          chk("hold_err", out_err, prev_e);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("sb_unexpected_out", 1, 0);
          else begin
            e = sb.pop_front();
            chk("sb_out", out, e.y);
            chk("sb_zero", out_zero, e.z);
            chk("sb_err", out_err, e.e);
          end
        end
        if (in_valid && in_ready) sb.push_back(ref_op(in_op, in1, in2));
        if (clr_cnt) mcnt = 0;
        else if (in_valid && in_ready && in_op == 3'd7 && mcnt < 15) mcnt++;
        stall_prev = out_valid && !out_ready;
        prev_out = out;
        prev_z = out_zero;
        prev_e = out_err;
      end
    end
  end

  initial begin
    logic [7:0] sweep_y [7];
    logic [7:0] bp_y [3];
    logic [7:0] got [$];
    sweep_y = '{8'h3A, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00};
    bp_y    = '{8'h30, 8'hFF, 8'h00};

    rst_n = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_count", err_count, 0);
    repeat (2) next();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Op sweep, back-to-back, results two cycles after issue.
    for (int t = 0; t < 9; t++) begin
      next();
      if (t < 7) drive(1'b1, 3'(t), 8'hC5, 8'h3A);
      else       drive(1'b0, 3'd0, 8'h00, 8'h00);
      @(negedge clk);
      if (t >= 2) begin
        chk("sweep_valid", out_valid, 1);
        chk("sweep_out", out, sweep_y[t-2]);
        chk("sweep_zero", out_zero, sweep_y[t-2] == 8'h00);
        chk("sweep_err", out_err, 0);
      end
    end

    // Illegal op.
    do_reset();
    drive(1'b1, 3'd7, 8'hFF, 8'h00);
    @(negedge clk);
    chk("ill_cnt_before", err_count, 0);
    next();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("ill_cnt_after", err_count, 1);
    next();
    @(negedge clk);
    chk("ill_valid", out_valid, 1);
    chk("ill_out", out, 8'h00);
    chk("ill_zero", out_zero, 1);
    chk("ill_err", out_err, 1);

    // Backpressure: three transactions against a stalled output.
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 8'hF0, 8'h3C);
    @(negedge clk);
    chk("bp_ready0", in_ready, 1);
    next();
    drive(1'b1, 3'd2, 8'hF0, 8'h0F);
    @(negedge clk);
    chk("bp_ready1", in_ready, 1);
    next();
    drive(1'b1, 3'd5, 8'hAA, 8'hAA);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("bp_ready_full", in_ready, 0);
      chk("bp_out_held", out, 8'h30);
      chk("bp_valid_held", out_valid, 1);
      if (c == 0) next();
    end
    next();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_release", in_ready, 1);
    got.delete();
    if (out_valid) got.push_back(out);
    for (int c = 0; c < 8; c++) begin
      next();
      drive(1'b0, 3'd0, 8'h00, 8'h00);
      @(negedge clk);
      if (out_valid) got.push_back(out);
    end
    chk("bp_count", got.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got.size()) chk("bp_order", got[i], bp_y[i]);

    // Saturation and clear priority.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 3'd7, 8'h5A, 8'hA5);
      next();
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    next();
    @(negedge clk);
    chk("sat_15", err_count, 15);
    next();
    next();
    @(negedge clk);
    chk("sat_hold", err_count, 15);
    next();
    clr_cnt = 1'b1;
    drive(1'b1, 3'd7, 8'hFF, 8'h00);
    next();
    clr_cnt = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("clr_priority", err_count, 0);

    // Asynchronous reset with both stages full.
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 3'd7, 8'h00, 8'h00);
    next();
    drive(1'b1, 3'd7, 8'h11, 8'h22);
    next();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("mid_full_valid", out_valid, 1);
    chk("mid_full_cnt", err_count, 2);
    chk("mid_full_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", err_count, 0);
    chk("mid_rst_out", out, 0);
    repeat (2) next();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'd2, 8'hC5, 8'h3A);
    @(negedge clk);
    chk("post_lat0", out_valid, 0);
    next();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("post_lat1", out_valid, 0);
    next();
    @(negedge clk);
    chk("post_lat2", out_valid, 1);
    chk("post_out", out, 8'hFF);
    chk("post_zero", out_zero, 0);

    // Random traffic checked by the scoreboard.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      next();
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            8'($urandom), 8'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      clr_cnt   = ($urandom_range(0, 63) == 0);
    end
    next();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    for (int c = 0; c < 10 && sb.size() != 0; c++) next();
    @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
